// File: rtl/rr_sel_arbiter.sv
// Round-robin burst arbiter for four requesters with the 4:1 data mux built in.
// Each owner holds the mux for up to MAX_BEATS cycles; handoff happens in a single edge.

module rr_sel_lane #(
   parameter int WIDTH = 1
) (
   input  logic             hit,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] q
);
   assign q = hit ? data : '0;
endmodule

module rr_sel_arbiter #(
   parameter int WIDTH     = 1,
   parameter int MAX_BEATS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] in,
   output logic [3:0]         grant,
   output logic [1:0]         sel,
   output logic [WIDTH-1:0]   out,
   output logic               valid,
   output logic               busy
);
   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_n;
   logic [1:0] ptr, ptr_n, sel_n;
   logic [3:0] beat, beat_n, grant_n;
   logic [3:0][WIDTH-1:0] lane_q;

   // {found, index} of the first requester at or after p, wrapping mod 4
   function automatic logic [2:0] scan(input logic [1:0] p, input logic [3:0] r);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 0; k < 4; k++) begin
         idx = p + 2'(k);
         if (r[idx] && !res[2]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         sel   <= '0;
         ptr   <= '0;
         beat  <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         sel   <= sel_n;
         ptr   <= ptr_n;
         beat  <= beat_n;
      end
   end

   always_comb begin
      logic [2:0] hit;
      state_n = state;
      grant_n = grant;
      sel_n   = sel;
      ptr_n   = ptr;
      beat_n  = beat;
      hit     = '0;
      case (state)
         IDLE: begin
            hit = scan(ptr, req);
            if (hit[2]) begin
               state_n = GRANT;
               sel_n   = hit[1:0];
               grant_n = 4'b0001 << hit[1:0];
               beat_n  = 4'd1;
            end
         end
         GRANT: begin
            if (req[sel] && beat < 4'(MAX_BEATS)) begin
               beat_n = beat + 4'd1;
            end else begin
               // release and rescan from the lane after the owner in the same edge
               ptr_n = sel + 2'd1;
               hit   = scan(sel + 2'd1, req);
               if (hit[2]) begin
                  sel_n   = hit[1:0];
                  grant_n = 4'b0001 << hit[1:0];
                  beat_n  = 4'd1;
               end else begin
                  state_n = IDLE;
                  grant_n = '0;
                  beat_n  = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   for (genvar i = 0; i < 4; i++) begin : g_lane
      rr_sel_lane #(.WIDTH(WIDTH)) u_lane (
         .hit  (valid && sel == 2'(i)),
         .data (in[i*WIDTH +: WIDTH]),
         .q    (lane_q[i])
      );
   end

   always_comb begin
      busy  = (state == GRANT);
      valid = busy && req[sel];
      out   = '0;
      for (int i = 0; i < 4; i++) out = out | lane_q[i];
   end

   a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_busy:   assert property (@(posedge clk) disable iff (rst) (grant != 4'b0) == busy);
   a_sel:    assert property (@(posedge clk) disable iff (rst) busy |-> grant == (4'b0001 << sel));
   a_beat:   assert property (@(posedge clk) disable iff (rst) beat <= 4'(MAX_BEATS));
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Scoreboard bench: directed stimulus pushes hand-computed expectations, a negedge monitor pops and compares.

module tb_rr_sel_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] in;
   logic [3:0] grant0, grant1;
   logic [1:0] sel0, sel1;
   logic       out0, out1, valid0, valid1, busy0, busy1;

   typedef struct {
      bit         d1;
      logic [3:0] grant;
      logic [1:0] sel;
      logic       valid;
      logic       busy;
      logic       out;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   rr_sel_arbiter #(.WIDTH(1), .MAX_BEATS(4)) u_dut (
      .clk(clk), .rst(rst), .req(req), .in(in),
      .grant(grant0), .sel(sel0), .out(out0), .valid(valid0), .busy(busy0)
   );

   rr_sel_arbiter #(.WIDTH(1), .MAX_BEATS(1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req), .in(in),
      .grant(grant1), .sel(sel1), .out(out1), .valid(valid1), .busy(busy1)
   );

   // drive one cycle after the edge and queue what the negedge should see
   task automatic cyc(input logic rs, input logic [3:0] r, input bit d1,
                      input logic [3:0] g, input logic [1:0] s,
                      input logic v, input logic b, input logic o, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst = rs;
      req = r;
      e.d1 = d1; e.grant = g; e.sel = s; e.valid = v; e.busy = b; e.out = o; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, "reset");
   endtask

   initial begin : monitor
      exp_t e;
      logic [8:0] act, want;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            act  = e.d1 ? {grant1, sel1, valid1, busy1, out1}
                        : {grant0, sel0, valid0, busy0, out0};
            want = {e.grant, e.sel, e.valid, e.busy, e.out};
            if (act !== want) begin
               miscompares++;
               $display("FAIL %s: got grant/sel/valid/busy/out=%b expected %b", e.name, act, want);
            end
         end
      end
   end

   initial begin : stim
      rst = 1'b1;
      req = 4'b0000;
      in  = 4'b0100;
      repeat (2) @(posedge clk);

      // reset state, then mid-grant asynchronous reset
      do_reset();
      cyc(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, "t1_idle");
      cyc(0, 4'b0100, 0, 4'b0000, 2'd0, 0, 0, 0, "t1_req_seen");
      cyc(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 1, 1, "t1_granted");
      cyc(1, 4'b0100, 0, 4'b0000, 2'd0, 0, 0, 0, "t1_async_rst");
      cyc(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, "t1_post_rst0");
      cyc(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, "t1_post_rst1");

      // single requester re-granted across burst boundaries with no gap
      cyc(0, 4'b0100, 0, 4'b0000, 2'd0, 0, 0, 0, "t2_wait");
      for (int k = 0; k < 10; k++)
         cyc(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 1, 1, $sformatf("t2_beat%0d", k));
      cyc(0, 4'b0000, 0, 4'b0100, 2'd2, 0, 1, 0, "t2_drop");
      cyc(0, 4'b0000, 0, 4'b0000, 2'd2, 0, 0, 0, "t2_idle_keep_sel");

      // all requesting: four beats each, wrap 3->0
      do_reset();
      in = 4'b1010;
      cyc(0, 4'b1111, 0, 4'b0000, 2'd0, 0, 0, 0, "t3_wait");
      for (int k = 0; k < 20; k++) begin
         logic [1:0] l;
         logic [3:0] inv;
         l   = 2'((k / 4) % 4);
         inv = 4'b1010;
         cyc(0, 4'b1111, 0, 4'b0001 << l, l, 1, 1, inv[l], $sformatf("t3_cyc%0d", k));
      end

      // early release by lane 1 hands off to lane 3
      do_reset();
      in = 4'b1000;
      cyc(0, 4'b1010, 0, 4'b0000, 2'd0, 0, 0, 0, "t4_wait");
      cyc(0, 4'b1010, 0, 4'b0010, 2'd1, 1, 1, 0, "t4_l1_b1");
      cyc(0, 4'b1010, 0, 4'b0010, 2'd1, 1, 1, 0, "t4_l1_b2");
      cyc(0, 4'b1000, 0, 4'b0010, 2'd1, 0, 1, 0, "t4_l1_drop");
      cyc(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 1, 1, "t4_l3_b1");
      cyc(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 1, 1, "t4_l3_b2");

      // MAX_BEATS=1 data path: rotate every cycle
      do_reset();
      in = 4'b1010;
      cyc(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, 0, "t5_wait");
      cyc(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 1, 0, "t5_sel0");
      cyc(0, 4'b1111, 1, 4'b0010, 2'd1, 1, 1, 1, "t5_sel1");
      cyc(0, 4'b1111, 1, 4'b0100, 2'd2, 1, 1, 0, "t5_sel2");
      cyc(0, 4'b1111, 1, 4'b1000, 2'd3, 1, 1, 1, "t5_sel3");
      cyc(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 1, 0, "t5_wrap");

      // idle return, then scan from ptr=1 wraps to lane 0
      do_reset();
      in = 4'b0001;
      cyc(0, 4'b0001, 0, 4'b0000, 2'd0, 0, 0, 0, "t6_wait");
      cyc(0, 4'b0000, 0, 4'b0001, 2'd0, 0, 1, 0, "t6_drop");
      cyc(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0, "t6_idle");
      cyc(0, 4'b0001, 0, 4'b0000, 2'd0, 0, 0, 0, "t6_rereq");
      cyc(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 1, 1, "t6_wrap_grant");

      repeat (2) @(posedge clk);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
